// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: instruction-memory request/response channel plus
// the in-order instruction hand-off to decode (including the branch redirect).
interface fetch_unit_if #(
    parameter int XLEN = 32
);
    // Instruction memory request (valid/ready) and fixed-latency response
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_addr;
    logic            imem_rsp_valid;
    logic [XLEN-1:0] imem_rdata;

    // Decode side: buffered head instruction and branch redirect
    logic            instr_valid;
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] instr_pc;
    logic            instr_ready;
    logic            PCSrc;
    logic [XLEN-1:0] ImmExt;

    // View from the fetch unit
    modport master (
        output imem_req_valid,
        input  imem_req_ready,
        output imem_addr,
        input  imem_rsp_valid,
        input  imem_rdata,
        output instr_valid,
        output instr,
        output instr_pc,
        input  instr_ready,
        input  PCSrc,
        input  ImmExt
    );

    // View from memory/decode environment
    modport slave (
        input  imem_req_valid,
        output imem_req_ready,
        input  imem_addr,
        output imem_rsp_valid,
        output imem_rdata,
        input  instr_valid,
        input  instr,
        input  instr_pc,
        output instr_ready,
        output PCSrc,
        output ImmExt
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, keeps at most one memory request in
// flight, buffers up to two fetched words with their PCs, and redirects to
// instr_pc + ImmExt when decode takes a branch, squashing younger fetches.
module fetch_unit #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic         clk,
    input  logic         rst,
    fetch_unit_if.master bus
);

    localparam int DEPTH = 2;

    // Architectural fetch state
    logic [XLEN-1:0] fetch_pc_reg, fetch_pc_next;
    logic [XLEN-1:0] req_pc_reg, req_pc_next;
    logic [1:0]      count_reg, count_next;
    logic            head_reg, head_next;
    logic            outstanding_reg, outstanding_next;
    logic            squash_reg, squash_next;
    // Holds requests off for the first cycle after reset releases
    logic            run_reg;

    // Two-entry buffer of {pc, word}
    logic [XLEN-1:0] pc_reg   [DEPTH];
    logic [XLEN-1:0] word_reg [DEPTH];
    logic [DEPTH-1:0] wr_en;

    // Per-cycle events
    logic            req_valid;
    logic            req_fire;
    logic            rsp_take;
    logic            head_valid;
    logic            pop;
    logic            redirect;
    logic            push;
    logic            wr_idx;
    logic [XLEN-1:0] target;

    // Request valid depends on registers only, so no input can reach it
    assign req_valid  = run_reg && !outstanding_reg && (count_reg != 2'd2);
    assign req_fire   = req_valid && bus.imem_req_ready;
    // Responses are meaningful only while a request is in flight
    assign rsp_take   = outstanding_reg && bus.imem_rsp_valid;
    assign head_valid = (count_reg != 2'd0);
    assign pop        = head_valid && bus.instr_ready;
    assign redirect   = pop && bus.PCSrc;
    // A squashed response, or any response in the redirect cycle, is dropped
    assign push       = rsp_take && !squash_reg && !redirect;
    // Tail slot is head + count (mod 2); count is at most 1 whenever a push occurs
    assign wr_idx     = head_reg ^ count_reg[0];
    assign target     = pc_reg[head_reg] + bus.ImmExt;

    assign bus.imem_req_valid = req_valid;
    assign bus.imem_addr      = fetch_pc_reg;
    assign bus.instr_valid    = head_valid;
    assign bus.instr          = word_reg[head_reg];
    assign bus.instr_pc       = pc_reg[head_reg];

    // Next-state computation for PC, in-flight tracking and buffer occupancy
    always_comb begin
        fetch_pc_next    = fetch_pc_reg;
        req_pc_next      = req_pc_reg;
        count_next       = count_reg;
        head_next        = head_reg;
        outstanding_next = outstanding_reg;
        squash_next      = squash_reg;

        if (req_fire) begin
            req_pc_next      = fetch_pc_reg;
            fetch_pc_next    = fetch_pc_reg + XLEN'(4);
            outstanding_next = 1'b1;
        end else if (rsp_take) begin
            outstanding_next = 1'b0;
        end

        if (rsp_take) begin
            squash_next = 1'b0;
        end

        case ({push, pop})
            2'b10:   count_next = count_reg + 2'd1;
            2'b01:   count_next = count_reg - 2'd1;
            default: count_next = count_reg;
        endcase

        if (pop) begin
            head_next = ~head_reg;
        end

        // Redirect overrides: flush the buffer and squash whatever is still in flight
        if (redirect) begin
            fetch_pc_next = target;
            count_next    = 2'd0;
            head_next     = 1'b0;
            squash_next   = req_fire || (outstanding_reg && !bus.imem_rsp_valid);
        end
    end

    // Control state register
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_reg    <= RESET_PC;
            req_pc_reg      <= RESET_PC;
            count_reg       <= 2'd0;
            head_reg        <= 1'b0;
            outstanding_reg <= 1'b0;
            squash_reg      <= 1'b0;
            run_reg         <= 1'b0;
        end else begin
            fetch_pc_reg    <= fetch_pc_next;
            req_pc_reg      <= req_pc_next;
            count_reg       <= count_next;
            head_reg        <= head_next;
            outstanding_reg <= outstanding_next;
            squash_reg      <= squash_next;
            run_reg         <= 1'b1;
        end
    end

    // One storage slot per buffer entry, written when it is the push target
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            assign wr_en[gi] = push && (int'(wr_idx) == gi);

            // Capture {req_pc, rdata} on push; cleared on reset so outputs read zero
            always_ff @(posedge clk) begin
                if (rst) begin
                    pc_reg[gi]   <= '0;
                    word_reg[gi] <= '0;
                end else if (wr_en[gi]) begin
                    pc_reg[gi]   <= req_pc_reg;
                    word_reg[gi] <= bus.imem_rdata;
                end
            end
        end
    endgenerate

endmodule
